// File: rtl/add32_seq_ctrl.sv
// 32-bit add/subtract sequencer: splits each operation into low and high halves
// on a shared external 16-bit carry-select adder, with valid/ready handshakes.
module add32_seq_ctrl #(
  parameter int unsigned SUB_EN = 1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_s,
  output logic        out_cout,
  output logic        out_ovf,
  output logic        busy,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_cin,
  input  logic [15:0] add_s,
  input  logic        add_cout,
  input  logic        add_last_cin_0,
  input  logic        add_last_cin_1
);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  state_e      r_state, w_state_next;
  logic [31:0] r_a, r_b, r_result;
  logic        r_sub, r_carry, r_cout, r_ovf;
  logic        w_sub, w_accept;

  assign w_sub    = (SUB_EN != 0) && in_sub;
  assign w_accept = (r_state == StIdle) && in_valid;

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    add_a        = 16'h0000;
    add_b        = 16'h0000;
    add_cin      = 1'b0;
    unique case (r_state)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = StLo;
      end
      StLo: begin
        add_a        = r_a[15:0];
        add_b        = r_b[15:0];
        add_cin      = r_sub;
        w_state_next = StHi;
      end
      StHi: begin
        add_a        = r_a[31:16];
        add_b        = r_b[31:16];
        add_cin      = r_carry;
        w_state_next = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= StIdle;
      r_a      <= 32'h0;
      r_b      <= 32'h0;
      r_sub    <= 1'b0;
      r_carry  <= 1'b0;
      r_result <= 32'h0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_a   <= in_a;
        // Subtraction as A + ~B + 1; the +1 enters through the low-half carry-in.
        r_b   <= w_sub ? ~in_b : in_b;
        r_sub <= w_sub;
      end
      if (r_state == StLo) begin
        r_result[15:0] <= add_s;
        r_carry        <= add_cout;
      end
      if (r_state == StHi) begin
        r_result[31:16] <= add_s;
        r_cout          <= add_cout;
        // Overflow = carry into bit 31 xor carry out of bit 31.
        r_ovf           <= (r_carry ? add_last_cin_1 : add_last_cin_0) ^ add_cout;
      end
    end
  end

  assign out_s    = r_result;
  assign out_cout = r_cout;
  assign out_ovf  = r_ovf;
  assign busy     = (r_state != StIdle);

endmodule

// File: tb/tb_add32_seq_ctrl.sv
// Self-checking bench: table vectors, hand-written corner sequences and random
// operations against an arithmetic reference model; SUB_EN=0 copy runs in lockstep.
module tb_add32_seq_ctrl;

  logic        clock = 1'b0;
  logic        resetn;
  logic        in_valid, in_sub, out_ready;
  logic [31:0] in_a, in_b;

  logic        in_ready, out_valid, out_cout, out_ovf, busy, add_cin;
  logic [31:0] out_s;
  logic [15:0] add_a, add_b, add_s;
  logic        add_cout, lc0, lc1;

  logic        d0_in_ready, d0_out_valid, d0_out_cout, d0_out_ovf, d0_busy, d0_add_cin;
  logic [31:0] d0_out_s;
  logic [15:0] d0_add_a, d0_add_b, d0_add_s;
  logic        d0_add_cout, d0_lc0, d0_lc1;

  always #5 clock = ~clock;

  // Behavioural 16-bit adder environment for each instance.
  logic [16:0] sum17, d0_sum17;
  logic [15:0] low0, low1, d0_low0, d0_low1;
  assign sum17       = {1'b0, add_a} + {1'b0, add_b} + {16'h0, add_cin};
  assign {add_cout, add_s} = sum17;
  assign low0        = {1'b0, add_a[14:0]} + {1'b0, add_b[14:0]};
  assign low1        = {1'b0, add_a[14:0]} + {1'b0, add_b[14:0]} + 16'd1;
  assign lc0         = low0[15];
  assign lc1         = low1[15];
  assign d0_sum17    = {1'b0, d0_add_a} + {1'b0, d0_add_b} + {16'h0, d0_add_cin};
  assign {d0_add_cout, d0_add_s} = d0_sum17;
  assign d0_low0     = {1'b0, d0_add_a[14:0]} + {1'b0, d0_add_b[14:0]};
  assign d0_low1     = {1'b0, d0_add_a[14:0]} + {1'b0, d0_add_b[14:0]} + 16'd1;
  assign d0_lc0      = d0_low0[15];
  assign d0_lc1      = d0_low1[15];

  add32_seq_ctrl #(.SUB_EN(1)) u_dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
    .out_ready(out_ready), .out_s(out_s), .out_cout(out_cout), .out_ovf(out_ovf),
    .busy(busy), .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s),
    .add_cout(add_cout), .add_last_cin_0(lc0), .add_last_cin_1(lc1)
  );

  add32_seq_ctrl #(.SUB_EN(0)) u_dut0 (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(d0_in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(d0_out_valid),
    .out_ready(out_ready), .out_s(d0_out_s), .out_cout(d0_out_cout),
    .out_ovf(d0_out_ovf), .busy(d0_busy), .add_a(d0_add_a), .add_b(d0_add_b),
    .add_cin(d0_add_cin), .add_s(d0_add_s), .add_cout(d0_add_cout),
    .add_last_cin_0(d0_lc0), .add_last_cin_1(d0_lc1)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input bit sub_en);
    res_t    r;
    longint  sa, sb, sr;
    longint unsigned ua, ub, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    if (sub && sub_en) begin
      sr     = sa - sb;
      ur     = ua - ub;
      r.cout = (ua >= ub);
    end else begin
      sr     = sa + sb;
      ur     = ua + ub;
      r.cout = (ur >= 64'h1_0000_0000);
    end
    r.s   = ur[31:0];
    r.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return r;
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic [31:0] es, input logic ec, input logic eo,
                       input int hold);
    res_t m0;
    m0 = model(a, b, sub, 1'b0);
    @(negedge clock);
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1; out_ready = (hold == 0);
    check("idle_ready", {31'h0, in_ready}, 32'h1);
    @(negedge clock);
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_sub = 1'($urandom_range(0, 1));
    check("lo_flags", {29'h0, in_ready, out_valid, busy}, 32'h1);
    check("lo_add_a", {16'h0, add_a}, {16'h0, a[15:0]});
    check("lo_add_cin", {31'h0, add_cin}, {31'h0, sub});
    @(negedge clock);
    check("hi_valid", {31'h0, out_valid}, 32'h0);
    check("hi_add_a", {16'h0, add_a}, {16'h0, a[31:16]});
    @(negedge clock);
    check("done_valid", {31'h0, out_valid}, 32'h1);
    check("done_s", out_s, es);
    check("done_cout", {31'h0, out_cout}, {31'h0, ec});
    check("done_ovf", {31'h0, out_ovf}, {31'h0, eo});
    check("done_add_a", {16'h0, add_a}, 32'h0);
    check("d0_s", d0_out_s, m0.s);
    check("d0_cout", {31'h0, d0_out_cout}, {31'h0, m0.cout});
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
      @(negedge clock);
      check("hold_valid", {31'h0, out_valid}, 32'h1);
      check("hold_ready", {31'h0, in_ready}, 32'h0);
      check("hold_s", out_s, es);
      check("hold_flags", {30'h0, out_cout, out_ovf}, {30'h0, ec, eo});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    check("post_flags", {29'h0, in_ready, out_valid, busy}, 32'h4);
    check("post_s_kept", out_s, es);
  endtask

  vec_t tbl[7];
  res_t m;

  initial begin
    tbl[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0};
    tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    tbl[2] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    tbl[3] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    tbl[4] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    tbl[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b1, 1'b0};
    tbl[6] = '{32'h0000000A, 32'h00000003, 1'b1, 32'h00000007, 1'b1, 1'b0};

    resetn = 1'b0; in_valid = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
    in_a = 32'h0; in_b = 32'h0;
    #12;
    check("rst_flags", {29'h0, in_ready, out_valid, busy}, 32'h4);
    check("rst_out", {out_s[31:2], out_cout, out_ovf} | {30'h0, out_s[1:0]}, 32'h0);
    check("rst_add", {add_a, add_b[15:1], add_cin | add_b[0]}, 32'h0);
    @(negedge clock);
    resetn = 1'b1;

    for (int i = 0; i < 7; i++)
      do_op(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].s, tbl[i].cout, tbl[i].ovf, 0);
    // Last table entry is 10 - 3; the SUB_EN=0 copy must have added instead.
    check("sub_en0_add", d0_out_s, 32'h0000000D);

    m = model(32'h12345678, 32'h0FEDCBA9, 1'b0, 1'b1);
    do_op(32'h12345678, 32'h0FEDCBA9, 1'b0, m.s, m.cout, m.ovf, 5);

    // Abort in HI: previous result is nonzero, so the clear is observable.
    @(negedge clock);
    in_a = 32'h0001FFFF; in_b = 32'h00000001; in_sub = 1'b0; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    resetn = 1'b0;
    #1;
    check("abort_flags", {29'h0, in_ready, out_valid, busy}, 32'h4);
    check("abort_s", out_s, 32'h0);
    check("abort_add", {add_a, add_b}, 32'h0);
    @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("abort_no_valid", {31'h0, out_valid}, 32'h0);
    end
    do_op(32'h0001FFFF, 32'h00000001, 1'b0, 32'h00020000, 1'b0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      logic        s;
      a = (i % 4 == 0) ? {$urandom_range(0, 1) ? 16'hFFFF : 16'h7FFF, 16'hFFFF} : $urandom;
      b = (i % 5 == 0) ? 32'h00000001 : $urandom;
      s = 1'($urandom_range(0, 1));
      m = model(a, b, s, 1'b1);
      do_op(a, b, s, m.s, m.cout, m.ovf, (i % 7 == 0) ? 2 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
